alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm responder FSM. Consumes the 1-cycle alarm-match pulse from the time comparator
//  and drives the buzzer. Handles stop/snooze buttons, a ring timeout and a snooze limit.
//  Sits between the comparator and the buzzer/status pads; timed by the 1 Hz sec_tick.
// PARAMETERS
//  RING_SECS    default 60  seconds of ringing before auto-stop (>=1)
//  SNOOZE_SECS  default 300 seconds of silence per snooze (>=1)
//  MAX_SNOOZE   default 3   snoozes allowed per alarm event (0 = snooze disabled)
// PORTS
//  clk        in  1  system clock
//  rst_n      in  1  reset, synchronous, active-low
//  sec_tick   in  1  1-cycle pulse, once per second
//  alarm_en   in  1  level; 0 = alarm armed off
//  H          in  1  1-cycle match pulse from the comparator
//  stop_btn   in  1  1-cycle pulse, debounced upstream
//  snooze_btn in  1  1-cycle pulse, debounced upstream
//  buzzer     out 1  buzzer drive
//  ringing    out 1  high in state RING
//  snoozing   out 1  high in state SNOOZE
//  snooze_cnt out $clog2(MAX_SNOOZE+1)  snoozes used in the current event
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, timer=0, snooze_cnt=0, all outputs 0.
//    Reset mid-RING/SNOOZE aborts to IDLE with no buzzer glitch.
//  - States: IDLE, RING, SNOOZE. All outputs are registered.
//  - IDLE->RING: H=1 and alarm_en=1 at a posedge. ringing=1 on the next edge (1-cycle
//    latency). On entry: timer<=RING_SECS, snooze_cnt<=0.
//  - RING->IDLE: stop_btn, or sec_tick while timer==1 (timeout).
//  - RING->SNOOZE: snooze_btn with snooze_cnt<MAX_SNOOZE. On entry: timer<=SNOOZE_SECS,
//    snooze_cnt+=1. If snooze_cnt==MAX_SNOOZE, snooze_btn is ignored and ringing continues.
//  - SNOOZE->RING: sec_tick while timer==1. On entry: timer<=RING_SECS; snooze_cnt is kept.
//  - SNOOZE->IDLE: stop_btn.
//  - Timer: decrements by 1 only on sec_tick; never underflows. Width
//    $clog2(max(RING_SECS,SNOOZE_SECS)+1).
//  - Priority for same-cycle events: !rst_n > !alarm_en > stop_btn > snooze_btn > timeout > H.
//  - alarm_en=0 forces IDLE on the next edge from any state. H is ignored in RING and SNOOZE,
//    so a re-match does not restart the event.
//  - snooze_cnt holds its value in IDLE until the next IDLE->RING.
// CONFIGURATION
//  BUZZ_PATTERN_EN defined: in RING, buzzer toggles on each sec_tick, giving 1 s on / 1 s off.
//    buzzer=1 on the first cycle of RING; forced 0 outside RING.
//  Not defined: buzzer == ringing, steady high throughout RING.
// STRUCTURE
//  Package alarm_pkg: state encodings (ST_IDLE=2'd0, ST_RING=2'd1, ST_SNOOZE=2'd2) and a
//    localparam helper for the timer width; shared with the comparator/top testbench.
//  Sub-module sec_countdown: load value, load strobe, sec_tick decrement, and an `expire`
//    output (tick && cnt==1). alarm_ctrl holds the FSM, snooze counter and buzzer logic.
// TESTING  (RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2, sec_tick every 10 clk)
//  1. H pulse, alarm_en=1 -> ringing=1 one clk later; 4 sec_ticks -> IDLE, buzzer=0.
//  2. RING, snooze_btn -> snoozing=1, snooze_cnt=1, buzzer=0; 3 ticks -> RING, 4 ticks -> IDLE.
//  3. Snooze twice; third snooze_btn in RING -> stays RING, snooze_cnt=2.
//  4. stop_btn and snooze_btn in the same cycle in RING -> IDLE, snooze_cnt unchanged.
//  5. H with alarm_en=0 -> stays IDLE. alarm_en dropped mid-SNOOZE -> IDLE next edge.
//  6. rst_n=0 mid-RING -> all outputs 0 next edge. With BUZZ_PATTERN_EN, buzzer=1,0,1,0
//     across ticks.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encodings and the timer width helper for the alarm block
package alarm_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_t;
  function automatic int timer_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/sec_countdown.sv
// sec_countdown: loadable seconds countdown; expire = tick while cnt==1, never underflows
// ports: clk, rst_n (sync, active-low), tick (1 Hz pulse), load, load_val[W-1:0] -> expire
module sec_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  assign expire = tick && cnt == W'(1);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm responder FSM (IDLE/RING/SNOOZE) driving buzzer and status outputs
// ports: clk, rst_n (sync, active-low), sec_tick, alarm_en, H, stop_btn, snooze_btn
//        -> buzzer, ringing, snoozing, snooze_cnt; all outputs registered
// BUZZ_PATTERN_EN: buzzer toggles on each sec_tick in RING (1 s on / 1 s off);
//        undefined: buzzer follows ringing
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  localparam int CW = MAX_SNOOZE > 0 ? $clog2(MAX_SNOOZE + 1) : 1,
  localparam int TW = timer_w(RING_SECS, SNOOZE_SECS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sec_tick,
  input  logic          alarm_en,
  input  logic          H,
  input  logic          stop_btn,
  input  logic          snooze_btn,
  output logic          buzzer,
  output logic          ringing,
  output logic          snoozing,
  output logic [CW-1:0] snooze_cnt
);
  state_t state;
  logic expire, go_ring, go_snz;
  always_comb begin
    go_snz  = alarm_en && !stop_btn && state == ST_RING && snooze_btn && snooze_cnt < CW'(MAX_SNOOZE);
    go_ring = alarm_en && !stop_btn && ((state == ST_IDLE && H) || (state == ST_SNOOZE && expire));
  end
  sec_countdown #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (sec_tick),
    .load     (go_ring || go_snz),
    .load_val (go_snz ? TW'(SNOOZE_SECS) : TW'(RING_SECS)),
    .expire   (expire)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= ST_IDLE;
      snooze_cnt <= '0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      buzzer     <= 1'b0;
    end else if (go_ring) begin
      state    <= ST_RING;
      ringing  <= 1'b1;
      snoozing <= 1'b0;
      buzzer   <= 1'b1;
      if (state == ST_IDLE) snooze_cnt <= '0;
    end else if (go_snz) begin
      state      <= ST_SNOOZE;
      ringing    <= 1'b0;
      snoozing   <= 1'b1;
      buzzer     <= 1'b0;
      snooze_cnt <= snooze_cnt + CW'(1);
    end else if (!alarm_en || stop_btn || (state == ST_RING && expire)) begin
      state    <= ST_IDLE;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
      buzzer   <= 1'b0;
    end
`ifdef BUZZ_PATTERN_EN
    else if (state == ST_RING && sec_tick) buzzer <= ~buzzer;
`endif
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: scoreboard bench for alarm_ctrl (RING=4, SNOOZE=3, MAX_SNOOZE=2, tick every 10 clk)
module tb_alarm_ctrl;
  logic clk = 0, rst_n = 0, sec_tick = 0, alarm_en = 0, H = 0, stop_btn = 0, snooze_btn = 0;
  logic buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;
  int tests = 0, fails = 0;
  typedef struct {string n; logic [4:0] v;} exp_t;
  exp_t eq[$];
  logic [4:0] oq[$];
`ifdef BUZZ_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  alarm_ctrl #(.RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sec_tick   (sec_tick),
    .alarm_en   (alarm_en),
    .H          (H),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] o(input logic r, input logic s, input logic b, input logic [1:0] c);
    return {r, s, b, c};
  endfunction

  function automatic logic rb(input int k);
    return PAT ? (k % 2 == 0) : 1'b1;
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
    sec_tick = 0; H = 0; stop_btn = 0; snooze_btn = 0;
  endtask

  task automatic step(input string n, input logic [4:0] v);
    eq.push_back('{n, v});
    clk1();
    oq.push_back({ringing, snoozing, buzzer, snooze_cnt});
  endtask

  task automatic tick_step(input string n, input logic [4:0] v);
    repeat (9) clk1();
    sec_tick = 1;
    step(n, v);
  endtask

  task automatic test_reset();
    exp_t e; logic [4:0] a;
    rst_n = 0; alarm_en = 1; H = 1;
    step("reset", o(0, 0, 0, 0));
    rst_n = 1;
    step("idle_after_reset", o(0, 0, 0, 0));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_ring_timeout();
    exp_t e; logic [4:0] a;
    H = 1;
    step("ring_entry", o(1, 0, 1, 0));
    for (int k = 1; k <= 3; k++) tick_step($sformatf("ring_tick%0d", k), o(1, 0, rb(k), 0));
    tick_step("ring_timeout", o(0, 0, 0, 0));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_snooze();
    exp_t e; logic [4:0] a;
    H = 1;
    step("snz_ring", o(1, 0, 1, 0));
    snooze_btn = 1;
    step("snooze_entry", o(0, 1, 0, 1));
    for (int k = 1; k <= 2; k++) tick_step("snoozing", o(0, 1, 0, 1));
    tick_step("snooze_expire", o(1, 0, 1, 1));
    for (int k = 1; k <= 3; k++) tick_step("re_ring", o(1, 0, rb(k), 1));
    tick_step("cnt_hold_idle", o(0, 0, 0, 1));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_snooze_limit();
    exp_t e; logic [4:0] a;
    H = 1;
    step("cnt_cleared", o(1, 0, 1, 0));
    for (int c = 1; c <= 2; c++) begin
      snooze_btn = 1;
      step("lim_snooze", o(0, 1, 0, 2'(c)));
      tick_step("lim_snoozing", o(0, 1, 0, 2'(c)));
      tick_step("lim_snoozing", o(0, 1, 0, 2'(c)));
      tick_step("lim_back", o(1, 0, 1, 2'(c)));
    end
    snooze_btn = 1;
    step("snooze_limit", o(1, 0, 1, 2));
    stop_btn = 1;
    step("lim_stop", o(0, 0, 0, 2));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_stop_snooze_same();
    exp_t e; logic [4:0] a;
    H = 1;
    step("ss_ring", o(1, 0, 1, 0));
    snooze_btn = 1;
    step("ss_snooze", o(0, 1, 0, 1));
    repeat (2) tick_step("ss_snoozing", o(0, 1, 0, 1));
    tick_step("ss_back", o(1, 0, 1, 1));
    stop_btn = 1; snooze_btn = 1;
    step("stop_beats_snooze", o(0, 0, 0, 1));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_alarm_en();
    exp_t e; logic [4:0] a;
    alarm_en = 0; H = 1;
    step("h_disabled", o(0, 0, 0, 1));
    alarm_en = 1; H = 1;
    step("en_ring", o(1, 0, 1, 0));
    snooze_btn = 1;
    step("en_snooze", o(0, 1, 0, 1));
    alarm_en = 0;
    step("en_drop", o(0, 0, 0, 1));
    alarm_en = 1;
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_rematch_priority();
    exp_t e; logic [4:0] a;
    H = 1;
    step("rm_ring", o(1, 0, 1, 0));
    tick_step("rm_t1", o(1, 0, rb(1), 0));
    tick_step("rm_t2", o(1, 0, rb(2), 0));
    H = 1;
    step("rematch_ignored", o(1, 0, rb(2), 0));
    tick_step("rm_t3", o(1, 0, rb(3), 0));
    tick_step("rematch_no_restart", o(0, 0, 0, 0));
    H = 1;
    step("pr_ring", o(1, 0, 1, 0));
    for (int k = 1; k <= 3; k++) tick_step("pr_tick", o(1, 0, rb(k), 0));
    repeat (9) clk1();
    sec_tick = 1; snooze_btn = 1;
    step("snooze_beats_timeout", o(0, 1, 0, 1));
    stop_btn = 1;
    step("stop_in_snooze", o(0, 0, 0, 1));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [4:0] a;
    H = 1;
    step("rst_ring", o(1, 0, 1, 0));
    tick_step("rst_tick", o(1, 0, rb(1), 0));
    rst_n = 0;
    step("reset_mid_ring", o(0, 0, 0, 0));
    rst_n = 1;
    step("post_reset_idle", o(0, 0, 0, 0));
    while (eq.size() > 0) begin
      e = eq.pop_front(); a = oq.pop_front(); tests++;
      if (a !== e.v) begin fails++; $display("FAIL %s: got r/s/b/cnt=%b required %b", e.n, a, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_snooze_limit();
    test_stop_snooze_same();
    test_alarm_en();
    test_rematch_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
